// File: rtl/mux_2to1_arbiter_pkg.sv
// rtl/mux_2to1_arbiter_pkg.sv - shared definitions for the two-requester output arbiter
//
// Holds the FSM state encoding, the parameter defaults used by mux_2to1_arbiter,
// and the burst counter width.
package mux_2to1_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_e;

    localparam int WIDTH_DEF     = 8;
    localparam int MAX_BURST_DEF = 4;
    localparam int BURST_CNT_W   = 4;

endpackage

// File: rtl/mux_2to1.sv
// rtl/mux_2to1.sv - single-bit two-input multiplexer
//
// Ports:
//   s0   select: 0 picks d0, 1 picks d1
//   d0   input 0
//   d1   input 1
//   out1 selected bit
module mux_2to1 (
    input  logic s0,
    input  logic d0,
    input  logic d1,
    output logic out1
);

    assign out1 = s0 ? d1 : d0;

endmodule

// File: rtl/mux_2to1_arbiter.sv
// rtl/mux_2to1_arbiter.sv - two-requester arbiter driving a shared WIDTH-bit mux
//
// Optional feature macro: MUX_2TO1_ARBITER_BURST_LIMIT_EN
//   defined   -> an owner is forced to hand over after MAX_BURST owned cycles
//                while the other requester is waiting
//   undefined -> no burst counter; an owner keeps the grant until its request drops
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   req0/req1  requests for the shared output
//   d0/d1      requester data, WIDTH bits
//   gnt0/gnt1  registered grants, never both high
//   s0         registered mux select (0 = d0, 1 = d1), held while idle
//   out1       s0 ? d1 : d0
//   valid_out  gnt0 | gnt1
module mux_2to1_arbiter
    import mux_2to1_arbiter_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             s0,
    output logic [WIDTH-1:0] out1,
    output logic             valid_out
);

    state_e state_q, state_d;
    logic   gnt0_q, gnt1_q;
    logic   s0_q;
    // 1 = requester 1 was served last, so requester 0 wins the next tie
    logic   last_q;
    logic   burst_done;
    logic   grant_entry;

    // A grant entry is any move into an owned state from somewhere else,
    // including a direct OWN0 <-> OWN1 handover.
    assign grant_entry = (state_d != IDLE) && (state_d != state_q);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (req0 && req1) begin
                    state_d = last_q ? OWN0 : OWN1;
                end else if (req0) begin
                    state_d = OWN0;
                end else if (req1) begin
                    state_d = OWN1;
                end
            end
            OWN0: begin
                if (!req0) begin
                    state_d = req1 ? OWN1 : IDLE;
                end else if (req1 && burst_done) begin
                    state_d = OWN1;
                end
            end
            OWN1: begin
                if (!req1) begin
                    state_d = req0 ? OWN0 : IDLE;
                end else if (req0 && burst_done) begin
                    state_d = OWN0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            s0_q    <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            gnt0_q  <= (state_d == OWN0);
            gnt1_q  <= (state_d == OWN1);
            if (grant_entry) begin
                s0_q   <= (state_d == OWN1);
                last_q <= (state_d == OWN1);
            end
        end
    end

`ifdef MUX_2TO1_ARBITER_BURST_LIMIT_EN
    localparam logic [BURST_CNT_W-1:0] MAX_BURST_C = BURST_CNT_W'(MAX_BURST);

    logic [BURST_CNT_W-1:0] burst_cnt_q, burst_cnt_d;

    // The counter holds owned cycles completed before the current one, so the
    // current cycle is the MAX_BURST-th owned cycle when count + 1 reaches it.
    assign burst_done = ({1'b0, burst_cnt_q} + 1'b1) >= {1'b0, MAX_BURST_C};

    always_comb begin
        burst_cnt_d = burst_cnt_q;
        if (grant_entry) begin
            burst_cnt_d = '0;
        end else if ((state_q != IDLE) && (burst_cnt_q < MAX_BURST_C)) begin
            burst_cnt_d = burst_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            burst_cnt_q <= '0;
        end else begin
            burst_cnt_q <= burst_cnt_d;
        end
    end
`else
    assign burst_done = 1'b0;
`endif

    assign gnt0      = gnt0_q;
    assign gnt1      = gnt1_q;
    assign s0        = s0_q;
    assign valid_out = gnt0_q | gnt1_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit_mux
        mux_2to1 u_mux (
            .s0   (s0_q),
            .d0   (d0[i]),
            .d1   (d1[i]),
            .out1 (out1[i])
        );
    end

endmodule
